// File: rtl/sound_square_channel.sv
`default_nettype none
// ============================================================================
// Module   : sound_square_channel
// Purpose  : Square-wave sound channel with optional frequency sweep, volume
//            envelope, length counter, 512 Hz frame sequencer and duty
//            waveform generator. Registers NRx0..NRx4 live at
//            BASE_ADDR..BASE_ADDR+4.
// Ports    : I_CLK          system clock
//            I_RESET        synchronous active-high reset
//            I_SOUND_EN     master sound enable; low holds everything in reset
//            I_IOREG_ADDR   register address
//            I_IOREG_WDATA  write data
//            I_IOREG_WE_L   active-low write strobe
//            O_IOREG_RDATA  masked readback (0xFF when not addressed)
//            O_IOREG_HIT    address falls inside this channel's window
//            O_CH_ON        channel enabled status
//            O_SAMPLE       4-bit output sample for the mixer
// Revision : 1.0 - initial release
// ============================================================================
module sound_square_channel #(
  parameter logic [15:0] BASE_ADDR          = 16'hFF10,
  parameter int          HAS_SWEEP          = 1,
  parameter int          CLKS_PER_FS_TICK   = 64453,
  parameter int          CLKS_PER_FREQ_TICK = 32
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_SOUND_EN,
  input  logic [15:0] I_IOREG_ADDR,
  input  logic [7:0]  I_IOREG_WDATA,
  input  logic        I_IOREG_WE_L,
  output logic [7:0]  O_IOREG_RDATA,
  output logic        O_IOREG_HIT,
  output logic        O_CH_ON,
  output logic [3:0]  O_SAMPLE
);

  localparam int c_FS_W = (CLKS_PER_FS_TICK > 1) ? $clog2(CLKS_PER_FS_TICK) : 1;
  localparam int c_FQ_W = (CLKS_PER_FREQ_TICK > 1) ? $clog2(CLKS_PER_FREQ_TICK) : 1;
  localparam logic [c_FS_W-1:0] c_FS_LAST = c_FS_W'(CLKS_PER_FS_TICK - 1);
  localparam logic [c_FQ_W-1:0] c_FQ_LAST = c_FQ_W'(CLKS_PER_FREQ_TICK - 1);
  localparam logic c_HAS_SWEEP = (HAS_SWEEP != 0);

  // Register file
  logic [7:0] r_nr0, r_nr1, r_nr2, r_nr3, r_nr4;

  // Channel state
  logic              r_on;
  logic [c_FS_W-1:0] r_fs_div;
  logic [2:0]        r_fs_step;
  logic [c_FQ_W-1:0] r_fq_div;
  logic [6:0]        r_len;
  logic [3:0]        r_vol;
  logic [2:0]        r_env_timer;
  logic [10:0]       r_shadow;
  logic [3:0]        r_sweep_timer;
  logic              r_sweep_en;
  logic [11:0]       r_period_timer;
  logic [2:0]        r_duty_pos;
  logic [3:0]        r_sample;

  // Sweep arithmetic in 12 bits so bit 11 flags an overflow past 2047.
  function automatic logic [11:0] f_sweep(input logic [10:0] sh,
                                          input logic [2:0]  shift,
                                          input logic        neg);
    logic [11:0] d;
    d = {1'b0, sh} >> shift;
    return neg ? ({1'b0, sh} - d) : ({1'b0, sh} + d);
  endfunction

  // ---------------------------------------------------------------- decode
  logic        w_rst;
  logic [15:0] w_offset;
  logic        w_hit, w_we;
  logic        w_wr0, w_wr1, w_wr2, w_wr3, w_wr4;
  logic        w_trig, w_dac_on, w_dac_off_wr;

  assign w_rst    = I_RESET | ~I_SOUND_EN;
  assign w_offset = I_IOREG_ADDR - BASE_ADDR;
  assign w_hit    = (w_offset < 16'd5);
  assign w_we     = ~I_IOREG_WE_L & w_hit;
  assign w_wr0    = w_we & (w_offset[2:0] == 3'd0) & c_HAS_SWEEP;
  assign w_wr1    = w_we & (w_offset[2:0] == 3'd1);
  assign w_wr2    = w_we & (w_offset[2:0] == 3'd2);
  assign w_wr3    = w_we & (w_offset[2:0] == 3'd3);
  assign w_wr4    = w_we & (w_offset[2:0] == 3'd4);
  assign w_trig   = w_wr4 & I_IOREG_WDATA[7];
  assign w_dac_on = |r_nr2[7:3];
  assign w_dac_off_wr = w_wr2 & (I_IOREG_WDATA[7:3] == 5'd0);

  // ------------------------------------------------------------- frequency
  logic [10:0] w_freq, w_trig_freq;
  logic [2:0]  w_sw_period, w_sw_shift;
  logic        w_sw_neg;
  logic [11:0] w_trig_new, w_sw_new;
  logic        w_trig_ovf;

  assign w_freq      = {r_nr4[2:0], r_nr3};
  // The trigger write carries the new frequency high bits itself.
  assign w_trig_freq = {I_IOREG_WDATA[2:0], r_nr3};
  assign w_sw_period = r_nr0[6:4];
  assign w_sw_neg    = r_nr0[3];
  assign w_sw_shift  = r_nr0[2:0];
  assign w_trig_new  = f_sweep(w_trig_freq, w_sw_shift, w_sw_neg);
  assign w_sw_new    = f_sweep(r_shadow, w_sw_shift, w_sw_neg);
  assign w_trig_ovf  = c_HAS_SWEEP & (w_sw_shift != 3'd0) & w_trig_new[11];

  // -------------------------------------------------------- timing strobes
  logic w_fs_tick, w_fq_tick, w_len_clk, w_env_clk, w_sweep_clk;

  assign w_fs_tick   = (r_fs_div == c_FS_LAST);
  assign w_fq_tick   = (r_fq_div == c_FQ_LAST);
  // The step clocked is the one held before the advance.
  assign w_len_clk   = w_fs_tick & ~r_fs_step[0];
  assign w_sweep_clk = w_fs_tick & (r_fs_step[1:0] == 2'b10) & c_HAS_SWEEP;
  assign w_env_clk   = w_fs_tick & (r_fs_step == 3'd7);

  // ---------------------------------------------------------- duty pattern
  logic [7:0] w_duty_pat;
  logic       w_duty_bit;

  // Patterns are written position 0 (MSB) to position 7 (LSB).
  always_comb begin
    w_duty_pat = 8'b0000_0001;
    case (r_nr1[7:6])
      2'd0:    w_duty_pat = 8'b0000_0001;
      2'd1:    w_duty_pat = 8'b1000_0001;
      2'd2:    w_duty_pat = 8'b1000_0111;
      default: w_duty_pat = 8'b0111_1110;
    endcase
  end

  assign w_duty_bit = w_duty_pat[3'd7 - r_duty_pos];

  // ------------------------------------------------------------- sequential
  always_ff @(posedge I_CLK) begin
    if (w_rst) begin
      r_nr0          <= 8'h00;
      r_nr1          <= 8'h00;
      r_nr2          <= 8'h00;
      r_nr3          <= 8'h00;
      r_nr4          <= 8'h00;
      r_on           <= 1'b0;
      r_fs_div       <= '0;
      r_fs_step      <= 3'd0;
      r_fq_div       <= '0;
      r_len          <= 7'd0;
      r_vol          <= 4'd0;
      r_env_timer    <= 3'd0;
      r_shadow       <= 11'd0;
      r_sweep_timer  <= 4'd0;
      r_sweep_en     <= 1'b0;
      r_period_timer <= 12'd0;
      r_duty_pos     <= 3'd0;
      r_sample       <= 4'd0;
    end else begin
      // Dividers
      if (w_fs_tick) begin
        r_fs_div  <= '0;
        r_fs_step <= r_fs_step + 3'd1;
      end else begin
        r_fs_div  <= r_fs_div + 1'b1;
      end
      r_fq_div <= w_fq_tick ? '0 : r_fq_div + 1'b1;

      if (w_trig) begin
        r_on           <= w_dac_on & ~w_trig_ovf;
        if (r_len == 7'd0) r_len <= 7'd64;
        r_period_timer <= 12'd2048 - {1'b0, w_trig_freq};
        r_vol          <= r_nr2[7:4];
        r_env_timer    <= r_nr2[2:0];
        r_shadow       <= w_trig_freq;
        r_sweep_timer  <= (w_sw_period == 3'd0) ? 4'd8 : {1'b0, w_sw_period};
        r_sweep_en     <= (w_sw_period != 3'd0) | (w_sw_shift != 3'd0);
      end else begin
        // Length counter
        if (w_len_clk && r_nr4[6] && (r_len != 7'd0)) begin
          r_len <= r_len - 7'd1;
          if (r_len == 7'd1) r_on <= 1'b0;
        end

        // Envelope; a zero timer is treated as already expired.
        if (w_env_clk && (r_nr2[2:0] != 3'd0)) begin
          if (r_env_timer <= 3'd1) begin
            r_env_timer <= r_nr2[2:0];
            if (r_nr2[3]) begin
              if (r_vol != 4'd15) r_vol <= r_vol + 4'd1;
            end else begin
              if (r_vol != 4'd0)  r_vol <= r_vol - 4'd1;
            end
          end else begin
            r_env_timer <= r_env_timer - 3'd1;
          end
        end

        // Sweep; a new frequency is written back into NRx3/NRx4[2:0].
        if (w_sweep_clk) begin
          if (r_sweep_timer <= 4'd1) begin
            r_sweep_timer <= (w_sw_period == 3'd0) ? 4'd8 : {1'b0, w_sw_period};
            if (r_sweep_en && (w_sw_period != 3'd0)) begin
              if (w_sw_new[11]) begin
                r_on <= 1'b0;
              end else if (w_sw_shift != 3'd0) begin
                r_shadow   <= w_sw_new[10:0];
                r_nr3      <= w_sw_new[7:0];
                r_nr4[2:0] <= w_sw_new[10:8];
              end
            end
          end else begin
            r_sweep_timer <= r_sweep_timer - 4'd1;
          end
        end

        // Period timer / duty position only run while the channel plays.
        if (r_on && w_fq_tick) begin
          if (r_period_timer <= 12'd1) begin
            r_period_timer <= 12'd2048 - {1'b0, w_freq};
            r_duty_pos     <= r_duty_pos + 3'd1;
          end else begin
            r_period_timer <= r_period_timer - 12'd1;
          end
        end
      end

      // CPU register writes land after the sweep write-back so they win.
      if (w_wr0) r_nr0 <= I_IOREG_WDATA;
      if (w_wr1) begin
        r_nr1 <= I_IOREG_WDATA;
        r_len <= 7'd64 - {1'b0, I_IOREG_WDATA[5:0]};
      end
      if (w_wr2) r_nr2 <= I_IOREG_WDATA;
      if (w_wr3) r_nr3 <= I_IOREG_WDATA;
      if (w_wr4) r_nr4 <= I_IOREG_WDATA;

      // Turning the DAC off wins over everything else that cycle.
      if (w_dac_off_wr) r_on <= 1'b0;

      r_sample <= w_duty_bit ? r_vol : 4'd0;
    end
  end

  // --------------------------------------------------------------- outputs
  always_comb begin
    O_IOREG_RDATA = 8'hFF;
    if (w_hit) begin
      case (w_offset[2:0])
        3'd0:    O_IOREG_RDATA = c_HAS_SWEEP ? (r_nr0 | 8'h80) : 8'hFF;
        3'd1:    O_IOREG_RDATA = r_nr1 | 8'h3F;
        3'd2:    O_IOREG_RDATA = r_nr2;
        3'd4:    O_IOREG_RDATA = r_nr4 | 8'hBF;
        default: O_IOREG_RDATA = 8'hFF;
      endcase
    end
  end

  assign O_IOREG_HIT = w_hit;
  assign O_CH_ON     = r_on;
  assign O_SAMPLE    = r_on ? r_sample : 4'd0;

endmodule

`default_nettype wire

// File: tb/tb_sound_square_channel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sound_square_channel
// Purpose  : Self-checking bench for sound_square_channel. Two instances
//            (sweep at 0xFF10, no sweep at 0xFF15) share the bus. Stimulus
//            pushes hand-computed expectations into a queue; a monitor on
//            the falling edge pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sound_square_channel;

  localparam int K_RD1 = 0, K_HIT1 = 1, K_ON1 = 2, K_S1 = 3;
  localparam int K_RD2 = 4, K_HIT2 = 5, K_ON2 = 6, K_S2 = 7;

  logic        clk = 1'b0;
  logic        rst, en, we_l;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rd1, rd2;
  logic        hit1, hit2, on1, on2;
  logic [3:0]  s1, s2;

  always #5 clk = ~clk;

  sound_square_channel #(
    .BASE_ADDR(16'hFF10), .HAS_SWEEP(1),
    .CLKS_PER_FS_TICK(8), .CLKS_PER_FREQ_TICK(1)
  ) u_ch1 (
    .I_CLK(clk), .I_RESET(rst), .I_SOUND_EN(en),
    .I_IOREG_ADDR(addr), .I_IOREG_WDATA(wdata), .I_IOREG_WE_L(we_l),
    .O_IOREG_RDATA(rd1), .O_IOREG_HIT(hit1), .O_CH_ON(on1), .O_SAMPLE(s1)
  );

  sound_square_channel #(
    .BASE_ADDR(16'hFF15), .HAS_SWEEP(0),
    .CLKS_PER_FS_TICK(8), .CLKS_PER_FREQ_TICK(1)
  ) u_ch2 (
    .I_CLK(clk), .I_RESET(rst), .I_SOUND_EN(en),
    .I_IOREG_ADDR(addr), .I_IOREG_WDATA(wdata), .I_IOREG_WE_L(we_l),
    .O_IOREG_RDATA(rd2), .O_IOREG_HIT(hit2), .O_CH_ON(on2), .O_SAMPLE(s2)
  );

  typedef struct {
    string      tag;
    int         kind;
    logic [7:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;
  int   cyc;

  // Clock edges since the last reset; frame-sequencer ticks fall on multiples
  // of 8, and the tick at edge c clocks step (c/8 - 1) mod 8.
  always @(posedge clk) begin
    if (rst || !en) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  // Monitor
  exp_t       m_e;
  logic [7:0] m_act;
  always @(negedge clk) begin
    while (q.size() > 0) begin
      m_e = q.pop_front();
      case (m_e.kind)
        K_RD1:   m_act = rd1;
        K_HIT1:  m_act = {7'd0, hit1};
        K_ON1:   m_act = {7'd0, on1};
        K_S1:    m_act = {4'd0, s1};
        K_RD2:   m_act = rd2;
        K_HIT2:  m_act = {7'd0, hit2};
        K_ON2:   m_act = {7'd0, on2};
        default: m_act = {4'd0, s2};
      endcase
      n_run++;
      if (m_act !== m_e.exp) begin
        n_fail++;
        $display("FAIL %s (cyc %0d): got 0x%02h, want 0x%02h", m_e.tag, cyc, m_act, m_e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(string tag, int kind, logic [7:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic wr(logic [15:0] a, logic [7:0] d);
    addr  = a;
    wdata = d;
    we_l  = 1'b0;
    tick();
    we_l  = 1'b1;
  endtask

  task automatic rd(string tag, int kind, logic [15:0] a, logic [7:0] v);
    addr = a;
    expect_v(tag, kind, v);
    tick();
  endtask

  task automatic upto(int c);
    while (cyc < c) tick();
    if (cyc != c) begin
      n_fail++;
      $display("FAIL sched: cyc %0d, want %0d", cyc, c);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; we_l = 1'b1; addr = 16'h0000; wdata = 8'h00;
    do_reset();

    // ---- reset readback / masks / hits
    expect_v("rst_on1", K_ON1, 8'h00);
    expect_v("rst_s1",  K_S1,  8'h00);
    expect_v("hit1_ff10", K_HIT1, 8'h01);
    rd("nr10_rst", K_RD1, 16'hFF10, 8'h80);
    rd("nr11_rst", K_RD1, 16'hFF11, 8'h3F);
    rd("nr12_rst", K_RD1, 16'hFF12, 8'h00);
    rd("nr13_rst", K_RD1, 16'hFF13, 8'hFF);
    expect_v("hit2_ff14", K_HIT2, 8'h00);
    rd("nr14_rst", K_RD1, 16'hFF14, 8'hBF);
    expect_v("hit1_ff15", K_HIT1, 8'h00);
    rd("nr20_rst", K_RD2, 16'hFF15, 8'hFF);
    rd("nr21_rst", K_RD2, 16'hFF16, 8'h3F);
    rd("nr22_rst", K_RD2, 16'hFF17, 8'h00);
    rd("nr23_rst", K_RD2, 16'hFF18, 8'hFF);
    expect_v("hit2_ff19", K_HIT2, 8'h01);
    rd("nr24_rst", K_RD2, 16'hFF19, 8'hBF);
    expect_v("hit1_ff0f", K_HIT1, 8'h00);
    rd("miss_rd1", K_RD1, 16'hFF0F, 8'hFF);
    expect_v("hit2_ff1a", K_HIT2, 8'h00);
    rd("miss_rd2", K_RD2, 16'hFF1A, 8'hFF);
    wr(16'hFF11, 8'h80);
    rd("nr11_80", K_RD1, 16'hFF11, 8'hBF);
    wr(16'hFF12, 8'hA5);
    rd("nr12_a5", K_RD1, 16'hFF12, 8'hA5);
    wr(16'hFF10, 8'h11);
    rd("nr10_11", K_RD1, 16'hFF10, 8'h91);
    wr(16'hFF14, 8'h47);
    rd("nr14_47", K_RD1, 16'hFF14, 8'hFF);

    // ---- duty 0 at freq 2047: position advances every cycle
    do_reset();
    wr(16'hFF12, 8'hF0);
    wr(16'hFF13, 8'hFF);
    wr(16'hFF14, 8'h87);             // trigger at edge T
    expect_v("duty_on", K_ON1, 8'h01);
    expect_v("duty_s_T", K_S1, 8'h00);
    for (int k = 1; k <= 16; k++) begin
      tick();
      expect_v($sformatf("duty0_k%0d", k), K_S1, (k == 8 || k == 16) ? 8'h0F : 8'h00);
    end
    wr(16'hFF11, 8'h80);             // duty 2 at edge T+17
    expect_v("duty2_k17", K_S1, 8'h00);
    for (int k = 18; k <= 25; k++) begin
      tick();
      expect_v($sformatf("duty2_k%0d", k), K_S1, (k >= 22) ? 8'h0F : 8'h00);
    end

    // ---- length: 2 clocks at steps 0 (edge 8) and 2 (edge 24)
    do_reset();
    wr(16'hFF11, 8'h3E);
    wr(16'hFF12, 8'hF0);
    wr(16'hFF14, 8'hC0);             // edge 3
    expect_v("len_on_trig", K_ON1, 8'h01);
    upto(8);
    expect_v("len_on_c8", K_ON1, 8'h01);
    upto(23);
    expect_v("len_on_c23", K_ON1, 8'h01);
    tick();
    expect_v("len_off_c24", K_ON1, 8'h00);

    // ---- envelope down from 5, period 1: step-7 clocks at 64,128,...
    do_reset();
    wr(16'hFF11, 8'h40);             // duty 1: position 0 is high
    wr(16'hFF12, 8'h51);
    wr(16'hFF13, 8'h00);
    wr(16'hFF14, 8'h80);             // edge 4
    expect_v("env_s_trig", K_S1, 8'h00);
    tick();
    expect_v("env_s_c5", K_S1, 8'h05);
    upto(64);
    expect_v("env_latency_c64", K_S1, 8'h05);
    tick();
    expect_v("env_vol4", K_S1, 8'h04);
    upto(129);
    expect_v("env_vol3", K_S1, 8'h03);
    upto(193);
    expect_v("env_vol2", K_S1, 8'h02);
    upto(257);
    expect_v("env_vol1", K_S1, 8'h01);
    upto(321);
    expect_v("env_vol0", K_S1, 8'h00);
    upto(385);
    expect_v("env_sat0", K_S1, 8'h00);
    expect_v("env_on", K_ON1, 8'h01);

    // ---- sweep: immediate overflow at trigger (0x600 -> 0x900)
    do_reset();
    wr(16'hFF10, 8'h11);
    wr(16'hFF12, 8'hF0);
    wr(16'hFF13, 8'h00);
    wr(16'hFF14, 8'h86);
    expect_v("sweep_trig_ovf", K_ON1, 8'h00);

    // ---- sweep: 0x400 -> 0x600 at edge 24, overflow at edge 56
    do_reset();
    wr(16'hFF10, 8'h11);
    wr(16'hFF12, 8'hF0);
    wr(16'hFF13, 8'h00);
    wr(16'hFF14, 8'h84);
    expect_v("sweep_on_trig", K_ON1, 8'h01);
    upto(24);
    expect_v("sweep_on_c24", K_ON1, 8'h01);
    upto(55);
    expect_v("sweep_on_c55", K_ON1, 8'h01);
    tick();
    expect_v("sweep_off_c56", K_ON1, 8'h00);

    // ---- no-sweep instance: NR20 ignored, no overflow, DAC-off write
    do_reset();
    wr(16'hFF15, 8'h11);
    rd("nr20_ignored", K_RD2, 16'hFF15, 8'hFF);
    wr(16'hFF17, 8'hF0);
    wr(16'hFF18, 8'h00);
    wr(16'hFF19, 8'h86);
    expect_v("ch2_on_trig", K_ON2, 8'h01);
    upto(60);
    expect_v("ch2_on_c60", K_ON2, 8'h01);
    wr(16'hFF17, 8'h00);
    expect_v("ch2_dac_off", K_ON2, 8'h00);
    expect_v("ch2_dac_off_s", K_S2, 8'h00);

    // ---- sound enable low resets registers and blocks writes
    wr(16'hFF16, 8'h80);
    wr(16'hFF17, 8'hF0);
    wr(16'hFF12, 8'hF3);
    wr(16'hFF19, 8'h80);
    expect_v("ch2_retrig_on", K_ON2, 8'h01);
    en = 1'b0;
    tick();
    expect_v("en_low_on2", K_ON2, 8'h00);
    rd("en_low_nr21", K_RD2, 16'hFF16, 8'h3F);
    rd("en_low_nr22", K_RD2, 16'hFF17, 8'h00);
    rd("en_low_nr12", K_RD1, 16'hFF12, 8'h00);
    wr(16'hFF17, 8'hF0);
    rd("en_low_wr_ignored", K_RD2, 16'hFF17, 8'h00);
    en = 1'b1;
    tick();
    rd("en_high_nr22", K_RD2, 16'hFF17, 8'h00);
    rd("en_high_nr11", K_RD1, 16'hFF11, 8'h3F);

    tick();
    tick();
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
